// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: datapath width, NOP encoding and fetch-queue depth.
package cpu_pkg;
  localparam int          W_DEFAULT     = 32;
  localparam int          DEPTH_DEFAULT = 4;
  localparam logic [31:0] NOP           = 32'h0000_0000;
endpackage

// File: rtl/if_id_queue.sv
// IF->ID fetch queue: circular FWFT FIFO, head visible the cycle after a push into an empty queue.
// Backpressure: IF_Stall while full (push refused even with a same-cycle pop); MEM_PCSrc flushes everything.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = W_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     IF_Valid,
  input  logic [W-1:0]             IF_PC,
  input  logic [W-1:0]             IF_PC4,
  input  logic [W-1:0]             IF_Inst,
  output logic                     IF_Stall,
  input  logic                     MEM_PCSrc,
  input  logic                     ID_Ready,
  output logic                     ID_Valid,
  output logic [W-1:0]             ID_PC,
  output logic [W-1:0]             ID_PC4,
  output logic [W-1:0]             ID_Inst,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_pc_mem   [DEPTH];
  logic [W-1:0]  r_pc4_mem  [DEPTH];
  logic [W-1:0]  r_inst_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_push  = IF_Valid & ~w_full & ~MEM_PCSrc;
  assign w_pop   = w_valid & ID_Ready & ~MEM_PCSrc;

  // Storage is never reset; the outputs are masked by w_valid instead.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= IF_PC;
      r_pc4_mem[r_tail]  <= IF_PC4;
      r_inst_mem[r_tail] <= IF_Inst;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (MEM_PCSrc) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign IF_Stall = w_full;
  assign ID_Valid = w_valid;
  assign ID_PC    = w_valid ? r_pc_mem[r_head]   : '0;
  assign ID_PC4   = w_valid ? r_pc4_mem[r_head]  : '0;
  assign ID_Inst  = w_valid ? r_inst_mem[r_head] : W'(NOP);
  assign Count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, hand-written corner sequences, randomized run vs a queue model.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int W     = 32;
  localparam logic [31:0] INST_KEY = 32'hDEAD_0000;

  logic          Clk = 1'b0;
  logic          Clr = 1'b1;
  logic          IF_Valid = 1'b0;
  logic [W-1:0]  IF_PC = '0;
  logic [W-1:0]  IF_PC4 = '0;
  logic [W-1:0]  IF_Inst = '0;
  logic          IF_Stall;
  logic          MEM_PCSrc = 1'b0;
  logic          ID_Ready = 1'b0;
  logic          ID_Valid;
  logic [W-1:0]  ID_PC;
  logic [W-1:0]  ID_PC4;
  logic [W-1:0]  ID_Inst;
  logic [2:0]    Count;

  if_id_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .Clk(Clk), .Clr(Clr),
    .IF_Valid(IF_Valid), .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst),
    .IF_Stall(IF_Stall), .MEM_PCSrc(MEM_PCSrc), .ID_Ready(ID_Ready),
    .ID_Valid(ID_Valid), .ID_PC(ID_PC), .ID_PC4(ID_PC4), .ID_Inst(ID_Inst),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fetch data derived from the PC so the table only needs to list PCs.
  task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] pc);
    IF_Valid  = v;
    ID_Ready  = r;
    MEM_PCSrc = f;
    IF_PC     = pc;
    IF_PC4    = pc + 32'd4;
    IF_Inst   = pc ^ INST_KEY;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        v, r, f;
    logic [31:0] pc;
    int          e_cnt;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_stall;
  } vec_t;

  typedef struct {
    logic [31:0] pc, pc4, inst;
  } ent_t;

  ent_t mq[$];

  // Reference: what the queue holds after one edge, given the inputs before it.
  task automatic model_edge(input logic v, input logic r, input logic f, input ent_t e);
    int  sz;
    logic do_pop, do_push;
    sz = mq.size();
    if (f) begin
      mq.delete();
    end else begin
      do_pop  = (sz > 0) && r;
      do_push = v && (sz < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endtask

  task automatic model_check(input int cyc);
    ent_t h;
    logic vld;
    vld = (mq.size() > 0);
    h   = '{pc: 32'h0, pc4: 32'h0, inst: 32'h0};
    if (vld) h = mq[0];
    chk($sformatf("rnd%0d count", cyc), {29'b0, Count}, mq.size());
    chk($sformatf("rnd%0d valid", cyc), {31'b0, ID_Valid}, {31'b0, vld});
    chk($sformatf("rnd%0d stall", cyc), {31'b0, IF_Stall}, {31'b0, mq.size() == DEPTH});
    chk($sformatf("rnd%0d pc", cyc),    ID_PC,   h.pc);
    chk($sformatf("rnd%0d pc4", cyc),   ID_PC4,  h.pc4);
    chk($sformatf("rnd%0d inst", cyc),  ID_Inst, h.inst);
  endtask

  initial begin
    vec_t tbl[$];
    ent_t e;
    logic [31:0] last_pc;

    // Reset state while Clr is held.
    #2;
    chk("reset count", {29'b0, Count}, 32'd0);
    chk("reset valid", {31'b0, ID_Valid}, 32'd0);
    chk("reset stall", {31'b0, IF_Stall}, 32'd0);
    chk("reset inst",  ID_Inst, 32'd0);
    @(negedge Clk);
    Clr = 1'b0;
    @(posedge Clk);
    #1;

    //            v     r     f     pc            cnt vld   pc            stall
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h00,  1, 1'b1, 32'h00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h04,  2, 1'b1, 32'h00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h08,  3, 1'b1, 32'h00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0C,  4, 1'b1, 32'h00,  1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h10,  4, 1'b1, 32'h00,  1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  3, 1'b1, 32'h04,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  2, 1'b1, 32'h08,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  1, 1'b1, 32'h0C,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  0, 1'b0, 32'h00,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  0, 1'b0, 32'h00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h20,  1, 1'b1, 32'h20,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h24,  2, 1'b1, 32'h20,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h28,  3, 1'b1, 32'h20,  1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h40,  0, 1'b0, 32'h00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h80,  1, 1'b1, 32'h80,  1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h84,  1, 1'b1, 32'h84,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  0, 1'b0, 32'h00,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h100, 1, 1'b1, 32'h100, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h104, 2, 1'b1, 32'h100, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h108, 3, 1'b1, 32'h100, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h10C, 4, 1'b1, 32'h100, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h110, 3, 1'b1, 32'h104, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h114, 4, 1'b1, 32'h104, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h00,  0, 1'b0, 32'h00,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h00,  0, 1'b0, 32'h00,  1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].pc);
      tick();
      chk($sformatf("vec%0d count", i), {29'b0, Count}, tbl[i].e_cnt);
      chk($sformatf("vec%0d valid", i), {31'b0, ID_Valid}, {31'b0, tbl[i].e_vld});
      chk($sformatf("vec%0d stall", i), {31'b0, IF_Stall}, {31'b0, tbl[i].e_stall});
      chk($sformatf("vec%0d pc", i), ID_PC, tbl[i].e_pc);
      chk($sformatf("vec%0d pc4", i), ID_PC4, tbl[i].e_vld ? tbl[i].e_pc + 32'd4 : 32'd0);
      chk($sformatf("vec%0d inst", i), ID_Inst, tbl[i].e_vld ? tbl[i].e_pc ^ INST_KEY : 32'd0);
    end

    // Streaming from empty: occupancy stays at one, head is always the last fetch.
    for (int i = 0; i < 20; i++) begin
      last_pc = 32'h1000 + 32'(i) * 32'd4;
      drive(1'b1, 1'b1, 1'b0, last_pc);
      tick();
      chk($sformatf("stream%0d count", i), {29'b0, Count}, 32'd1);
      chk($sformatf("stream%0d pc", i), ID_PC, last_pc);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("stream drained", {29'b0, Count}, 32'd0);

    // Asynchronous clear between edges with two entries held.
    drive(1'b1, 1'b0, 1'b0, 32'h300);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h304);
    tick();
    chk("pre-clr count", {29'b0, Count}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2 Clr = 1'b1;
    #1;
    chk("clr count",   {29'b0, Count}, 32'd0);
    chk("clr valid",   {31'b0, ID_Valid}, 32'd0);
    chk("clr pc",      ID_PC, 32'd0);
    chk("clr stall",   {31'b0, IF_Stall}, 32'd0);
    Clr = 1'b0;
    #1;
    chk("post-clr count", {29'b0, Count}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h200);
    tick();
    chk("after-clr push valid", {31'b0, ID_Valid}, 32'd1);
    chk("after-clr push pc", ID_PC, 32'h200);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();

    // Randomized run against the queue model; start from a known empty state.
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      e.pc   = $urandom;
      e.pc4  = $urandom;
      e.inst = $urandom;
      IF_Valid  = ($urandom_range(0, 9) < 7);
      ID_Ready  = ($urandom_range(0, 9) < 5);
      MEM_PCSrc = ($urandom_range(0, 19) == 0);
      IF_PC     = e.pc;
      IF_PC4    = e.pc4;
      IF_Inst   = e.inst;
      model_edge(IF_Valid, ID_Ready, MEM_PCSrc, e);
      tick();
      model_check(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch-queue entries; power of two, 2..16.
REQ-002 Parameter W, default 32, width of PC, PC4 and instruction fields.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Clr  input  1  reset, asynchronous, active-high.
REQ-005 IF_Valid  input  1  IF stage presents a fetched instruction this cycle.
REQ-006 IF_PC  input  W  PC of the fetched instruction.
REQ-007 IF_PC4  input  W  PC+4 of the fetched instruction.
REQ-008 IF_Inst  input  W  fetched instruction word.
REQ-009 IF_Stall  output  1  queue full; IF shall hold its PC.
REQ-010 MEM_PCSrc  input  1  taken branch or jump resolved in MEM; flushes the queue.
REQ-011 ID_Ready  input  1  ID stage accepts the head entry this cycle.
REQ-012 ID_Valid  output  1  head entry valid.
REQ-013 ID_PC  output  W  PC of head entry.
REQ-014 ID_PC4  output  W  PC+4 of head entry.
REQ-015 ID_Inst  output  W  head instruction; NOP (all zeros) when ID_Valid=0.
REQ-016 Count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-017 Queue shall be a circular FIFO with head/tail pointers wrapping modulo DEPTH and an occupancy counter 0..DEPTH.
REQ-018 Push shall occur on an edge when IF_Valid=1, Count<DEPTH and MEM_PCSrc=0.
REQ-019 Pop shall occur on an edge when ID_Valid=1, ID_Ready=1 and MEM_PCSrc=0.
REQ-020 Simultaneous push and pop shall leave Count unchanged and advance both pointers.
REQ-021 IF_Stall shall equal (Count==DEPTH), combinational from registered Count; push is refused when full even if a pop occurs in the same cycle.
REQ-022 Output shall be first-word-fall-through: an entry pushed at edge N is presented on ID_* during cycle N+1 if the queue was empty.
REQ-023 ID_Valid shall equal (Count!=0); ID_PC, ID_PC4 and ID_Inst shall be zero when ID_Valid=0.
REQ-024 MEM_PCSrc=1 at an edge shall set Count=0 and both pointers to 0, discarding any concurrent push and pop; ID_Valid=0 in the following cycle.
REQ-025 A push in the cycle after a flush shall be accepted normally (no dead cycle).
REQ-026 Pop with Count=0 and push with Count=DEPTH shall never change state.
REQ-027 Entry fields (PC, PC4, Inst) shall be stored and returned bit-exact; no arithmetic on PC values.

Reset
REQ-028 Clr=1 shall immediately set Count=0, head=0, tail=0, forcing ID_Valid=0, ID_*=0 and IF_Stall=0, independent of Clk.
REQ-029 Storage array contents need not be reset; outputs are masked by REQ-023.
REQ-030 Clr asserted mid-operation shall discard all entries; first push after deassertion lands in entry 0.

Structure
REQ-031 Shared package cpu_pkg shall hold W, the NOP encoding (32'h0000_0000) and the default DEPTH.
REQ-032 No sub-module; storage array, pointers and counter live in if_id_queue.

Verification
REQ-033 Fill: IF_Valid=1, ID_Ready=0, PCs 0x00,0x04,0x08,0x0C -> Count=4, IF_Stall=1 after 4th edge, 5th fetch not stored.
REQ-034 Drain order: after fill, ID_Ready=1 for 4 cycles -> ID_PC sequence 0x00,0x04,0x08,0x0C, then ID_Valid=0, ID_Inst=0.
REQ-035 Streaming: IF_Valid=1 and ID_Ready=1 continuously for 20 cycles from empty -> Count stays 1, ID_PC lags IF_PC by one cycle, pointers wrap without loss.
REQ-036 Flush: Count=3, MEM_PCSrc=1 with IF_Valid=1 (PC 0x40) -> next cycle Count=0, ID_Valid=0, 0x40 not stored; push of 0x80 next edge appears on ID_PC.
REQ-037 Async reset: Clr pulsed between edges with Count=2 -> ID_Valid=0, Count=0 before next edge; first subsequent push appears at ID.
